// File: rtl/filter_seq_pkg.sv
// Shared types and constants for the filter sequencer: FSM encoding,
// coefficient width and the default watchdog limit.
package filter_seq_pkg;

    localparam int COEF_W      = 4;
    localparam int DEF_TIMEOUT = 64;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;

    typedef struct packed {
        logic [COEF_W-1:0] a1;
        logic [COEF_W-1:0] a2;
    } coef_t;

endpackage

// File: rtl/filter_sequencer_rate_divider.sv
// Sample-rate period counter: one tick every period+1 enabled cycles.
module rate_divider #(
    parameter int DIVWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [DIVWIDTH-1:0] period,
    output logic                tick
);

    logic [DIVWIDTH-1:0] cnt;

    // Equality compare only: a period lowered below cnt lets cnt wrap around.
    assign tick = enable && (cnt == period);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/filter_sequencer.sv
// Sequences one filter pass per sample tick: capture, start pulse, watchdog-
// guarded wait for done, result register, shadowed coefficients, sticky errors.
module filter_sequencer
    import filter_seq_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int DIVWIDTH  = 16,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIVWIDTH-1:0]  period,
    input  logic [DATAWIDTH-1:0] sample_in,
    input  logic [COEF_W-1:0]    cfg_a1,
    input  logic [COEF_W-1:0]    cfg_a2,
    input  logic                 cfg_load,
    input  logic                 err_clr,
    output logic [DATAWIDTH-1:0] filt_in,
    output logic                 filt_once,
    output logic [COEF_W-1:0]    filt_a1,
    output logic [COEF_W-1:0]    filt_a2,
    input  logic                 filt_done,
    input  logic [DATAWIDTH-1:0] filt_out,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_overrun,
    output state_t               fsm_state
);

    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_t         state;
    logic [WDW-1:0] wdog;
    coef_t          shadow;
    logic           pending;
    logic           tick;
    logic           timeout_hit;
    logic           overrun_hit;

    rate_divider #(
        .DIVWIDTH(DIVWIDTH)
    ) u_rate_divider (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .period(period),
        .tick  (tick)
    );

    always_comb begin
        timeout_hit = 1'b0;
        overrun_hit = 1'b0;
        if (state == ST_WAIT && !filt_done && wdog == WD_LAST) begin
            timeout_hit = 1'b1;
        end
        if (tick && state != ST_IDLE) begin
            overrun_hit = 1'b1;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wdog        <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            filt_in     <= '0;
            filt_once   <= 1'b0;
            filt_a1     <= '0;
            filt_a2     <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            filt_once <= 1'b0;
            out_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        filt_a1 <= shadow.a1;
                        filt_a2 <= shadow.a2;
                    end
                    if (tick) begin
                        filt_in   <= sample_in;
                        filt_once <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wdog  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (filt_done) begin
                        out_data  <= filt_out;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (wdog == WD_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A load in the same IDLE cycle as the copy stays pending for the next one.
            if (cfg_load) begin
                shadow.a1 <= cfg_a1;
                shadow.a2 <= cfg_a2;
                pending   <= 1'b1;
            end else if (state == ST_IDLE) begin
                pending <= 1'b0;
            end

            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end

            if (overrun_hit) begin
                err_overrun <= 1'b1;
            end else if (err_clr) begin
                err_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_filter_sequencer.sv
// Self-checking bench for filter_sequencer: table-driven single-pass vectors,
// hand-written corner sequences and a randomized run against a timing model.
module tb_filter_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] period = '0;
    logic [15:0] sample_in = '0;
    logic [3:0]  cfg_a1 = '0;
    logic [3:0]  cfg_a2 = '0;
    logic        cfg_load = 1'b0;
    logic        err_clr = 1'b0;
    logic        filt_done = 1'b0;
    logic [15:0] filt_out = '0;
    logic [15:0] filt_in;
    logic        filt_once;
    logic [3:0]  filt_a1;
    logic [3:0]  filt_a2;
    logic [15:0] out_data;
    logic        out_valid;
    logic        busy;
    logic        err_timeout;
    logic        err_overrun;
    logic [1:0]  fsm_state;

    filter_sequencer #(
        .DATAWIDTH(16),
        .DIVWIDTH (16),
        .TIMEOUT  (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .period     (period),
        .sample_in  (sample_in),
        .cfg_a1     (cfg_a1),
        .cfg_a2     (cfg_a2),
        .cfg_load   (cfg_load),
        .err_clr    (err_clr),
        .filt_in    (filt_in),
        .filt_once  (filt_once),
        .filt_a1    (filt_a1),
        .filt_a2    (filt_a2),
        .filt_done  (filt_done),
        .filt_out   (filt_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Filter stand-in: done fm_lat cycles after once, unless withheld.
    int          fm_lat = 4;
    int          fm_due = 0;
    bit          fm_armed = 1'b0;
    bit          fm_hold = 1'b0;
    logic [15:0] fm_val = '0;

    function automatic logic [15:0] filt_fn(input logic [15:0] x, input logic [7:0] c);
        return x + 16'd1 + {8'd0, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // After return, outputs of cycle cyc are visible and inputs set now apply to cycle cyc.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        cfg_load = 1'b0;
        err_clr  = 1'b0;
        if (filt_once) begin
            fm_due   = cyc + fm_lat;
            fm_val   = filt_fn(filt_in, {filt_a1, filt_a2});
            fm_armed = !fm_hold;
        end
        filt_done = fm_armed && (cyc == fm_due);
        filt_out  = filt_done ? fm_val : 16'($urandom);
        if (filt_done) fm_armed = 1'b0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) cycle();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        enable   = 1'b0;
        fm_armed = 1'b0;
        fm_hold  = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_filt_in"}, 32'(filt_in), 0);
        chk({tag, "_once"}, 32'(filt_once), 0);
        chk({tag, "_a"}, 32'({filt_a1, filt_a2}), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_errs"}, 32'({err_timeout, err_overrun}), 0);
    endtask

    typedef struct {
        logic [15:0] per;
        logic [15:0] smp;
        int          lat;
        int          once_at;
        int          valid_at;
        logic [15:0] data;
        int          once2_at;
        logic        ovr;
    } vec_t;

    vec_t vecs[4];

    // Randomized-run reference model: pass timing from tick time and latency.
    int          m_p, m_lat, m_t0, m_free, m_once_at, m_valid_at;
    logic [15:0] m_in, m_data, m_pass_data;
    logic [7:0]  m_act, m_sh;
    bit          m_pend, m_ovr;

    task automatic rcycle();
        bit idle, tick;
        sample_in = 16'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            cfg_load = 1'b1;
            cfg_a1   = 4'($urandom);
            cfg_a2   = 4'($urandom);
        end
        err_clr = ($urandom_range(0, 15) == 0);
        idle = (cyc >= m_free);
        tick = enable && (((cyc - m_t0) % (m_p + 1)) == m_p);
        if (idle && m_pend) begin
            m_act  = m_sh;
            m_pend = 1'b0;
        end
        if (cfg_load) begin
            m_sh   = {cfg_a1, cfg_a2};
            m_pend = 1'b1;
        end
        if (tick && idle) begin
            m_once_at   = cyc + 1;
            m_in        = sample_in;
            m_valid_at  = cyc + 2 + m_lat;
            m_pass_data = filt_fn(sample_in, m_act);
            m_free      = cyc + 2 + m_lat;
        end
        if (tick && !idle) m_ovr = 1'b1;
        else if (err_clr) m_ovr = 1'b0;
        cycle();
        if (cyc == m_valid_at) m_data = m_pass_data;
        chk("r_once", 32'(filt_once), 32'(cyc == m_once_at));
        chk("r_filt_in", 32'(filt_in), 32'(m_in));
        chk("r_valid", 32'(out_valid), 32'(cyc == m_valid_at));
        chk("r_out_data", 32'(out_data), 32'(m_data));
        chk("r_coefs", 32'({filt_a1, filt_a2}), 32'(m_act));
        chk("r_busy", 32'(busy), 32'(cyc < m_free));
        chk("r_overrun", 32'(err_overrun), 32'(m_ovr));
        chk("r_timeout", 32'(err_timeout), 0);
    endtask

    initial begin
        int t0, got_once, got_once2, got_valid, nvalid, nonce;
        logic [15:0] got_data;

        vecs[0] = '{16'd9, 16'd100, 4, 10, 15, 16'd101, 20, 1'b0};
        vecs[1] = '{16'd0, 16'hFFFF, 1, 1, 3, 16'h0000, 4, 1'b1};
        vecs[2] = '{16'd3, 16'd0, 2, 4, 7, 16'd1, 8, 1'b0};
        vecs[3] = '{16'd5, 16'd1234, 6, 6, 13, 16'd1235, 18, 1'b1};

        // Reset state
        do_reset();
        chk_all_zero("reset");
        chk("reset_state", 32'(fsm_state), 0);

        // Table-driven single-rate vectors
        for (int i = 0; i < 4; i++) begin
            do_reset();
            period    = vecs[i].per;
            sample_in = vecs[i].smp;
            fm_lat    = vecs[i].lat;
            enable    = 1'b1;
            t0 = cyc;
            got_once = -1; got_once2 = -1; got_valid = -1; got_data = '0;
            for (int k = 0; k < 40; k++) begin
                cycle();
                if (filt_once && got_once >= 0 && got_once2 < 0) got_once2 = cyc - t0;
                if (filt_once && got_once < 0) begin
                    got_once = cyc - t0;
                    chk("vec_filt_in", 32'(filt_in), 32'(vecs[i].smp));
                end
                if (out_valid && got_valid < 0) begin
                    got_valid = cyc - t0;
                    got_data  = out_data;
                end
            end
            chk("vec_once_at", got_once, vecs[i].once_at);
            chk("vec_valid_at", got_valid, vecs[i].valid_at);
            chk("vec_data", 32'(got_data), 32'(vecs[i].data));
            chk("vec_once2_at", got_once2, vecs[i].once2_at);
            chk("vec_overrun", 32'(err_overrun), 32'(vecs[i].ovr));
        end

        // Timeout, late done in IDLE, recovery and err_clr
        do_reset();
        period = 16'd9; fm_lat = 4; fm_hold = 1'b1; sample_in = 16'd50; enable = 1'b1;
        t0 = cyc; nvalid = 0;
        while (!err_timeout && cyc < t0 + 100) begin
            cycle();
            if (out_valid) nvalid++;
        end
        chk("to_at", cyc - t0, 75);
        chk("to_no_valid", nvalid, 0);
        chk("to_idle", 32'(busy), 0);
        fm_hold   = 1'b0;
        filt_done = 1'b1;
        filt_out  = 16'hBEEF;
        cycle();
        chk("late_done_valid", 32'(out_valid), 0);
        chk("late_done_data", 32'(out_data), 0);
        chk("late_done_busy", 32'(busy), 0);
        while (!filt_once && cyc < t0 + 100) cycle();
        chk("to_next_once", cyc - t0, 80);
        while (!out_valid && cyc < t0 + 100) cycle();
        chk("to_next_valid", cyc - t0, 85);
        chk("to_next_data", 32'(out_data), 51);
        chk("to_overrun_set", 32'(err_overrun), 1);
        err_clr = 1'b1;
        cycle();
        chk("clr_errs", 32'({err_timeout, err_overrun}), 0);

        // Overrun at period 0, set wins over clear
        do_reset();
        period = 16'd0; fm_lat = 4; sample_in = 16'd7; enable = 1'b1;
        t0 = cyc; nvalid = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (out_valid) nvalid++;
        end
        chk("ovr_passes", nvalid, 5);
        chk("ovr_flag", 32'(err_overrun), 1);
        cycle();
        err_clr = 1'b1;
        cycle();
        chk("ovr_set_wins", 32'(err_overrun), 1);
        enable  = 1'b0;
        err_clr = 1'b1;
        cycle();
        chk("ovr_cleared", 32'(err_overrun), 0);

        // Coefficient shadowing
        do_reset();
        period = 16'd9; fm_lat = 4; sample_in = 16'd200; enable = 1'b1;
        t0 = cyc;
        run_to(t0 + 12);
        cfg_load = 1'b1; cfg_a1 = 4'd3; cfg_a2 = 4'd5;
        for (int k = 13; k <= 15; k++) begin
            cycle();
            chk("cfg_hold_busy", 32'({filt_a1, filt_a2}), 0);
        end
        cycle();
        chk("cfg_applied", 32'({filt_a1, filt_a2}), 32'h35);
        run_to(t0 + 19);
        cfg_load = 1'b1; cfg_a1 = 4'd7; cfg_a2 = 4'd2;
        cycle();
        chk("cfg_tick_once", 32'(filt_once), 1);
        chk("cfg_tick_old", 32'({filt_a1, filt_a2}), 32'h35);
        run_to(t0 + 25);
        chk("cfg_pass_valid", 32'(out_valid), 1);
        chk("cfg_pass_data", 32'(out_data), 254);
        chk("cfg_still_old", 32'({filt_a1, filt_a2}), 32'h35);
        cycle();
        chk("cfg_new", 32'({filt_a1, filt_a2}), 32'h72);

        // Reset in WAIT
        do_reset();
        period = 16'd9; fm_lat = 4; sample_in = 16'h1234; enable = 1'b1;
        t0 = cyc;
        run_to(t0 + 12);
        chk("rst_pre_busy", 32'(busy), 1);
        rst = 1'b1;
        cycle();
        chk_all_zero("rst_wait");
        rst = 1'b0;
        nvalid = 0;
        while (cyc < t0 + 16) begin
            cycle();
            if (out_valid) nvalid++;
        end
        chk("rst_done_ignored", nvalid, 0);
        while (!filt_once && cyc < t0 + 40) cycle();
        chk("rst_resume_once", cyc - t0, 23);
        while (!out_valid && cyc < t0 + 40) cycle();
        chk("rst_resume_valid", cyc - t0, 28);
        chk("rst_resume_data", 32'(out_data), 32'h1235);

        // Enable dropped mid-pass
        do_reset();
        period = 16'd9; fm_lat = 4; sample_in = 16'd77; enable = 1'b1;
        t0 = cyc;
        run_to(t0 + 11);
        enable = 1'b0;
        while (!out_valid && cyc < t0 + 40) cycle();
        chk("en_drop_valid_at", cyc - t0, 15);
        chk("en_drop_data", 32'(out_data), 78);
        nonce = 0;
        while (cyc < t0 + 45) begin
            cycle();
            if (filt_once) nonce++;
        end
        chk("en_drop_no_once", nonce, 0);
        enable = 1'b1;
        t0 = cyc;
        cycle();
        while (!filt_once && cyc < t0 + 40) cycle();
        chk("en_restart_once", cyc - t0, 10);

        // Randomized segments against the reference model
        do_reset();
        m_p = 0; m_lat = 1; m_t0 = 0; m_free = 0; m_once_at = -1; m_valid_at = -1;
        m_in = '0; m_data = '0; m_pass_data = '0; m_act = '0; m_sh = '0;
        m_pend = 1'b0; m_ovr = 1'b0;
        for (int seg = 0; seg < 6; seg++) begin
            enable = 1'b0;
            for (int k = 0; k < 10; k++) rcycle();
            m_p    = int'($urandom_range(0, 12));
            m_lat  = int'($urandom_range(1, 6));
            period = 16'(m_p);
            fm_lat = m_lat;
            enable = 1'b1;
            m_t0   = cyc;
            for (int k = 0; k < 150; k++) rcycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/filter_sequencer.md
# filter_sequencer

Control block that drives the two-stage IIR `filter` datapath at a programmable sample rate. A period counter generates sample ticks; on each tick the block captures the input sample, issues a one-cycle `once` start, waits for `done` under a watchdog, and registers the result. Coefficient updates are shadowed and applied only between passes. Missed ticks and hung passes are flagged.

## Interface
- `DATAWIDTH`, 16, sample width of filter input and output
- `DIVWIDTH`, 16, width of the sample-period register
- `TIMEOUT`, 64, maximum cycles spent in WAIT before abort; must be ≥2
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run the tick generator.
- `period` in DIVWIDTH: tick interval is period+1 cycles.
- `sample_in` in DATAWIDTH: ADC sample, captured on tick.
- `cfg_a1`, `cfg_a2` in 4: requested stage coefficients.
- `cfg_load` in 1: pulse; latch cfg_a* into the shadow register.
- `err_clr` in 1: clear sticky error flags.
- `filt_in` out DATAWIDTH: filter `in`.
- `filt_once` out 1: filter `once` start pulse.
- `filt_a1`, `filt_a2` out 4: active coefficients.
- `filt_done` in 1: filter `done`.
- `filt_out` in DATAWIDTH: filter `out`.
- `out_data` out DATAWIDTH: last filtered sample.
- `out_valid` out 1: one-cycle strobe on `out_data` update.
- `busy` out 1: state ≠ IDLE.
- `err_timeout` out 1: sticky, a pass was aborted.
- `err_overrun` out 1: sticky, a tick was dropped.

## Operation
- Tick generator: `cnt` counts 0..period. `tick` = enable & (cnt == period); on tick `cnt` ← 0, else `cnt`+1. With enable low, `cnt` is held at 0. period=0 gives a tick every cycle. A period change takes effect at the next compare, and if cnt > period, cnt counts up and wraps at 2^DIVWIDTH.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: pending shadow coefs are copied to `filt_a*` and pending is cleared. On tick, `filt_in` ← sample_in and the FSM goes to ISSUE.
  - ISSUE: `filt_once`=1 for exactly this cycle, `wdog` ← 0, then WAIT.
  - WAIT: on `filt_done`, `out_data` ← filt_out, `out_valid`=1 next cycle, then IDLE. If wdog reaches TIMEOUT-1 without done, set `err_timeout` and go to IDLE with no out_valid. Otherwise wdog+1.
- `filt_done` is ignored outside WAIT, so a late done after an abort has no effect.
- A tick while not IDLE is dropped and sets `err_overrun`.
- `cfg_load` in any state sets pending and overwrites the shadow; the last load wins. `filt_a*` never change outside IDLE. If load and tick arrive in the same IDLE cycle, the new coefs apply in the next IDLE cycle, so that pass uses the old coefs.
- `err_clr` clears both sticky flags. If a set event coincides with err_clr, set wins.
- Deasserting enable does not abort an in-flight pass.
- Reset: state IDLE, cnt 0, wdog 0, pending 0. All outputs 0: filt_in, filt_once, filt_a1, filt_a2, out_data, out_valid, busy, err_*. Reset mid-pass abandons the pass with no out_valid.

## Timing
- Tick at cycle T (IDLE): filt_in is valid at T+1 and filt_once=1 at T+1. WAIT starts at T+2.
- filt_done sampled at cycle D ≥ T+2: out_data and out_valid are valid at D+1, IDLE at D+1.
- Minimum pass is 3 cycles after the tick. The next tick is accepted at D+1.
- Timeout: abort with err_timeout=1 at T+2+TIMEOUT when no done arrives. WAIT occupies TIMEOUT cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `filter_seq_pkg`: state enum (IDLE, ISSUE, WAIT), coefficient width constant (4), default TIMEOUT.
- Sub-module `rate_divider` (period counter → tick). The FSM, shadow registers, watchdog and flags stay in the top module.

## Test plan
- period=9, enable=1, filter model returns done 4 cycles after once with out = in+1 → once pulses every 10 cycles; out_valid 5 cycles after each once; sample 100 gives out_data=101.
- Model withholds done, TIMEOUT=64 → err_timeout=1 at tick+66, no out_valid, next tick starts a new pass. A late done while IDLE is ignored. err_clr → flag 0.
- period=0 with a 4-cycle filter → ticks during WAIT set err_overrun, and exactly one pass completes per (done latency+2) window.
- cfg_load a1=3,a2=5 during WAIT → filt_a* unchanged until return to IDLE, then 3/5. Load coincident with a tick → that pass uses the old coefs.
- rst asserted in WAIT → all outputs 0 next cycle, a subsequent done is ignored, and normal ticking resumes after rst is released.
- enable dropped mid-pass → pass completes with out_valid. No further once pulses, and cnt holds at 0.
